// File: rtl/clk_div_bank.sv
// clk_div_bank -- bank of independent programmable clock dividers / tick
// generators running off the board clock.
//
// Each channel counts 0..M_act and produces either a 50% square wave
// (MODE=0) or a one-cycle strobe (MODE=1), plus a one-cycle TICK per period.
// New limits arrive over a valid/ready port and are held in a shadow
// register until the channel's next wrap (or immediately if the channel is
// stopped), so a period in flight always completes with its old length.
//
// Ports:
//   CLOCK      in   single rising-edge clock
//   RESET      in   synchronous active-high reset
//   EN         in   [CHANNELS] per-channel run enable
//   MODE       in   [CHANNELS] 0 = square wave, 1 = strobe
//   CFG_VALID  in   configuration request
//   CFG_CH     in   [CH_W] target channel; out-of-range values are ignored
//   CFG_M      in   [WIDTH] new limit
//   CFG_READY  out  combinational; low while the target channel has a
//                   limit waiting to apply, high for out-of-range channels
//   CLK_OUT    out  [CHANNELS] registered divided clock / strobe
//   TICK       out  [CHANNELS] registered one-cycle pulse per period

// ---------------------------------------------------------------------------
// One divider channel.
//   clk/rst  clock and synchronous reset
//   en       run enable; counter and square output freeze when low
//   mode     0 = square, 1 = strobe
//   wr       limit transfer accepted this edge (only when !pending)
//   wr_m     limit being transferred
//   pending  shadow holds a limit not yet applied
//   clk_out  divided clock / strobe
//   tick     one-cycle pulse at the start of every period
// ---------------------------------------------------------------------------
module clk_div_chan #(
    parameter int          WIDTH   = 32,
    parameter logic [WIDTH-1:0] RESET_M = WIDTH'(2499)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_m,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] m_act;
    logic [WIDTH-1:0] m_sh;
    logic             ev;
    logic             wrap;

    // '>=' rather than '==' so a counter that somehow overshoots the limit
    // still returns to 0 on the next enabled edge.
    assign wrap = (cnt >= m_act);
    assign ev   = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            m_act   <= RESET_M;
            m_sh    <= RESET_M;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (en)
                cnt <= wrap ? '0 : cnt + 1'b1;

            tick <= ev;

            // Mode is sampled every edge, so a switch to strobe mode drops a
            // high square output unless this edge is itself an event.
            if (mode)
                clk_out <= ev;
            else if (ev)
                clk_out <= ~clk_out;

            // Apply at the wrap so the running period finishes at its old
            // length; a stopped channel has no period to protect.
            if (pending && (!en || wrap)) begin
                m_act   <= m_sh;
                pending <= 1'b0;
            end

            // wr is only ever asserted while pending is clear, so it never
            // collides with the apply above. A transfer on a wrap edge lands
            // in the shadow and waits for the following wrap.
            if (wr) begin
                m_sh    <= wr_m;
                pending <= 1'b1;
            end
        end
    end

endmodule

// ---------------------------------------------------------------------------
// Top: configuration decode plus an array of channels.
// ---------------------------------------------------------------------------
module clk_div_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    parameter int CH_W     = 2,
    parameter int RESET_M  = 2499
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] EN,
    input  logic [CHANNELS-1:0] MODE,
    input  logic                CFG_VALID,
    input  logic [CH_W-1:0]     CFG_CH,
    input  logic [WIDTH-1:0]    CFG_M,
    output logic                CFG_READY,
    output logic [CHANNELS-1:0] CLK_OUT,
    output logic [CHANNELS-1:0] TICK
);

    typedef struct packed {
        logic             vld;
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] m;
    } cfg_req_t;

    cfg_req_t            cfg_req;
    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] sel;
    logic [CHANNELS-1:0] wr;

    assign cfg_req = '{vld: CFG_VALID, ch: CFG_CH, m: CFG_M};

    // One-hot channel decode. An out-of-range index matches nothing, which
    // both leaves ready high and suppresses any write.
    always_comb begin
        sel = '0;
        for (int i = 0; i < CHANNELS; i++)
            sel[i] = (cfg_req.ch == CH_W'(i));
    end

    assign CFG_READY = ~|(sel & pend);
    assign wr        = {CHANNELS{cfg_req.vld}} & sel & ~pend;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        clk_div_chan #(
            .WIDTH   (WIDTH),
            .RESET_M (WIDTH'(RESET_M))
        ) u_chan (
            .clk     (CLOCK),
            .rst     (RESET),
            .en      (EN[c]),
            .mode    (MODE[c]),
            .wr      (wr[c]),
            .wr_m    (cfg_req.m),
            .pending (pend[c]),
            .clk_out (CLK_OUT[c]),
            .tick    (TICK[c])
        );
    end

endmodule
